// File: rtl/redun_mont_pkg.sv
// Shared types and constants for the redundant Montgomery squarer and its output collapse stage.
// Optional feature macro used by dependents: REDUN_COLLAPSE_CNT_EN (exposes the subtraction count).
package redun_mont_pkg;

    localparam int unsigned NUM_WRDS      = 8;
    localparam int unsigned WRD_BITS      = 16;
    localparam int unsigned DAT_BITS      = NUM_WRDS * WRD_BITS;
    localparam int unsigned COLLAPSE_BITS = DAT_BITS + 2;

    localparam logic [DAT_BITS-1:0] P = 128'h2d4f_9a13_77c1_0e5b_c3a8_6f02_91d7_4b3d;

    // Redundant value: each word carries one extra (redundant) bit above WRD_BITS.
    typedef struct packed {
        logic [NUM_WRDS-1:0][WRD_BITS:0] wrd;
    } redun0_t;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_CARRY  = 4'b0010,
        ST_REDUCE = 4'b0100,
        ST_DONE   = 4'b1000
    } collapse_state_t;

    // Binary value to redundant form with all redundant bits clear.
    function automatic redun0_t to_redun(input logic [DAT_BITS-1:0] x);
        redun0_t r;
        for (int i = 0; i < int'(NUM_WRDS); i++) begin
            r.wrd[i] = {1'b0, x[i*WRD_BITS +: WRD_BITS]};
        end
        return r;
    endfunction

endpackage

// File: rtl/redun_mont_collapse_if.sv
// Handshake bundle between the squarer, the collapse stage and the readback logic.
// REDUN_COLLAPSE_CNT_EN adds o_sub_cnt (subtractions performed, valid with o_val).
interface redun_mont_collapse_if
`ifdef REDUN_COLLAPSE_CNT_EN
    #(parameter int unsigned MAX_SUB = 2)
`endif
    ;
    import redun_mont_pkg::*;

    redun0_t               i_dat;
    logic                  i_val;
    logic                  o_rdy;
    logic [DAT_BITS-1:0]   o_dat;
    logic                  o_val;
    logic                  i_rdy;
    logic                  o_ovf;

`ifdef REDUN_COLLAPSE_CNT_EN
    localparam int unsigned SUB_W = $clog2(MAX_SUB + 1);
    logic [SUB_W-1:0]      o_sub_cnt;

    modport slave  (input i_dat, i_val, i_rdy, output o_rdy, o_dat, o_val, o_ovf, o_sub_cnt);
    modport master (output i_dat, i_val, i_rdy, input o_rdy, o_dat, o_val, o_ovf, o_sub_cnt);
`else
    modport slave  (input i_dat, i_val, i_rdy, output o_rdy, o_dat, o_val, o_ovf);
    modport master (output i_dat, i_val, i_rdy, input o_rdy, o_dat, o_val, o_ovf);
`endif

endinterface

// File: rtl/redun_carry_slice.sv
// Combinational carry ripple over CARRY_WRDS redundant words; disabled words pass through.
module redun_carry_slice
    import redun_mont_pkg::*;
#(
    parameter int unsigned CARRY_WRDS = 4
) (
    input  logic [CARRY_WRDS-1:0][WRD_BITS:0]   wrd_in,
    input  logic [CARRY_WRDS-1:0]               wrd_en,
    input  logic [1:0]                          carry_in,
    output logic [CARRY_WRDS-1:0][WRD_BITS-1:0] wrd_out_c,
    output logic [1:0]                          carry_out_c
);

    // Ripple: word + 2-bit carry needs WRD_BITS+2 bits so a full redundant word never loses carry.
    always_comb begin
        logic [1:0]            c;
        logic [WRD_BITS+1:0]   s;
        c           = carry_in;
        s           = '0;
        wrd_out_c   = '0;
        for (int k = 0; k < int'(CARRY_WRDS); k++) begin
            s = {1'b0, wrd_in[k]} + (WRD_BITS+2)'(c);
            if (wrd_en[k]) begin
                wrd_out_c[k] = s[WRD_BITS-1:0];
                c            = s[WRD_BITS+1:WRD_BITS];
            end else begin
                wrd_out_c[k] = wrd_in[k][WRD_BITS-1:0];
            end
        end
        carry_out_c = c;
    end

endmodule

// File: rtl/redun_mont_collapse.sv
// Collapses a redundant Montgomery result to canonical binary and reduces it mod P
// with at most MAX_SUB subtractions.
// REDUN_COLLAPSE_CNT_EN: adds o_sub_cnt on the bus (subtractions performed).
module redun_mont_collapse
    import redun_mont_pkg::*;
#(
    parameter int unsigned CARRY_WRDS = 4,
    parameter int unsigned MAX_SUB    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    redun_mont_collapse_if.slave  bus
);

    localparam int unsigned SUB_W = $clog2(MAX_SUB + 1);
    localparam int unsigned PTR_W = $clog2(NUM_WRDS + CARRY_WRDS) + 1;
    localparam int unsigned IDX_W = $clog2(NUM_WRDS);

    collapse_state_t                      state;
    logic [NUM_WRDS-1:0][WRD_BITS:0]      acc;
    logic [NUM_WRDS-1:0][WRD_BITS:0]      acc_nxt;
    logic [1:0]                           carry_r;
    logic [PTR_W-1:0]                     ptr;
    logic [SUB_W-1:0]                     sub_cnt;
    logic [COLLAPSE_BITS-1:0]             val;

    logic [CARRY_WRDS-1:0][WRD_BITS:0]    slice_in;
    logic [CARRY_WRDS-1:0]                slice_en;
    logic [CARRY_WRDS-1:0][WRD_BITS-1:0]  slice_out_c;
    logic [1:0]                           slice_carry_c;
    logic [COLLAPSE_BITS-1:0]             collapsed_c;
    logic [COLLAPSE_BITS:0]               diff_c;
    logic                                 last_c;
    logic                                 sub_ok_c;

    // Gather the current window of words; words past the top are masked off.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = '0;
        slice_in = '0;
        slice_en = '0;
        for (int k = 0; k < int'(CARRY_WRDS); k++) begin
            idx = ptr + PTR_W'(k);
            if (idx < PTR_W'(NUM_WRDS)) begin
                slice_en[k] = 1'b1;
                slice_in[k] = acc[IDX_W'(idx)];
            end
        end
    end

    redun_carry_slice #(
        .CARRY_WRDS (CARRY_WRDS)
    ) u_slice (
        .wrd_in      (slice_in),
        .wrd_en      (slice_en),
        .carry_in    (carry_r),
        .wrd_out_c   (slice_out_c),
        .carry_out_c (slice_carry_c)
    );

    // Scatter rippled words back and form the collapsed value for the final window.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx         = '0;
        acc_nxt     = acc;
        collapsed_c = '0;
        for (int k = 0; k < int'(CARRY_WRDS); k++) begin
            idx = ptr + PTR_W'(k);
            if (slice_en[k]) begin
                acc_nxt[IDX_W'(idx)] = {1'b0, slice_out_c[k]};
            end
        end
        for (int i = 0; i < int'(NUM_WRDS); i++) begin
            collapsed_c[i*WRD_BITS +: WRD_BITS] = acc_nxt[i][WRD_BITS-1:0];
        end
        collapsed_c[COLLAPSE_BITS-1 -: 2] = slice_carry_c;
    end

    assign last_c   = (ptr + PTR_W'(CARRY_WRDS)) >= PTR_W'(NUM_WRDS);
    assign diff_c   = {1'b0, val} - (COLLAPSE_BITS+1)'(P);
    assign sub_ok_c = !diff_c[COLLAPSE_BITS] && (sub_cnt < SUB_W'(MAX_SUB));

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            bus.o_rdy <= 1'b1;
            bus.o_val <= 1'b0;
            bus.o_ovf <= 1'b0;
            bus.o_dat <= '0;
            acc       <= '0;
            carry_r   <= '0;
            ptr       <= '0;
            sub_cnt   <= '0;
            val       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_val) begin
                        acc       <= bus.i_dat.wrd;
                        carry_r   <= '0;
                        ptr       <= '0;
                        sub_cnt   <= '0;
                        bus.o_rdy <= 1'b0;
                        state     <= ST_CARRY;
                    end
                end
                ST_CARRY: begin
                    acc     <= acc_nxt;
                    carry_r <= slice_carry_c;
                    ptr     <= ptr + PTR_W'(CARRY_WRDS);
                    if (last_c) begin
                        val   <= collapsed_c;
                        state <= ST_REDUCE;
                    end
                end
                ST_REDUCE: begin
                    if (sub_ok_c) begin
                        val     <= diff_c[COLLAPSE_BITS-1:0];
                        sub_cnt <= sub_cnt + SUB_W'(1);
                    end else begin
                        bus.o_dat <= val[DAT_BITS-1:0];
                        bus.o_ovf <= !diff_c[COLLAPSE_BITS];
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!bus.o_val) begin
                        bus.o_val <= 1'b1;
                    end else if (bus.i_rdy) begin
                        bus.o_val <= 1'b0;
                        bus.o_rdy <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    bus.o_val <= 1'b0;
                    bus.o_rdy <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef REDUN_COLLAPSE_CNT_EN
    // Capture the subtraction count alongside the result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.o_sub_cnt <= '0;
        end else if (state == ST_REDUCE && !sub_ok_c) begin
            bus.o_sub_cnt <= sub_cnt;
        end
    end
`else
    // Count stays internal: it only bounds the reduction loop.
`endif

endmodule

// File: tb/tb_redun_mont_collapse.sv
// Bench for redun_mont_collapse: directed vector table, reset corner case and randomized
// transactions against an arithmetic reference. Honors REDUN_COLLAPSE_CNT_EN.
module tb_redun_mont_collapse;
    import redun_mont_pkg::*;

    localparam int unsigned CW = 4;
    localparam int unsigned MS = 2;
    localparam int          NC = (int'(NUM_WRDS) + int'(CW) - 1) / int'(CW);

    logic i_clk = 1'b0;
    logic i_rst;

    always #5 i_clk = ~i_clk;

    redun_mont_collapse_if bus ();

    redun_mont_collapse #(
        .CARRY_WRDS (CW),
        .MAX_SUB    (MS)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    int cmp_cnt  = 0;
    int mism_cnt = 0;

    typedef struct {
        redun0_t              dat;
        logic [DAT_BITS-1:0]  exp_dat;
        bit                   exp_ovf;
        int                   exp_s;
        int                   hold;
    } vec_t;

    task automatic chk(input string name, input logic [DAT_BITS-1:0] act, input logic [DAT_BITS-1:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            mism_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: sum weighted words, then subtract P while allowed.
    function automatic void model(input redun0_t d, output logic [DAT_BITS-1:0] res,
                                  output bit ovf, output int s);
        logic [COLLAPSE_BITS-1:0] v;
        v = '0;
        for (int i = 0; i < int'(NUM_WRDS); i++) begin
            v = v + (COLLAPSE_BITS'(d.wrd[i]) << (int'(WRD_BITS) * i));
        end
        s = 0;
        while (v >= COLLAPSE_BITS'(P) && s < int'(MS)) begin
            v = v - COLLAPSE_BITS'(P);
            s++;
        end
        ovf = (v >= COLLAPSE_BITS'(P));
        res = v[DAT_BITS-1:0];
    endfunction

    task automatic run_txn(input redun0_t d, input logic [DAT_BITS-1:0] exp_dat, input bit exp_ovf,
                           input int exp_s, input int hold, input bit early_rdy, input bit junk,
                           input string tag);
        int cyc;
        cyc = 0;
        while (bus.o_rdy !== 1'b1 && cyc < 50) begin
            @(posedge i_clk); #1;
            cyc++;
        end
        chk({tag, " idle_rdy"}, DAT_BITS'(bus.o_rdy), 1);
        bus.i_dat = d;
        bus.i_val = 1'b1;
        bus.i_rdy = early_rdy;
        @(posedge i_clk); #1;
        bus.i_val = junk;
        if (junk) bus.i_dat = ~d;
        chk({tag, " busy_rdy"}, DAT_BITS'(bus.o_rdy), 0);
        cyc = 0;
        while (bus.o_val !== 1'b1 && cyc < 100) begin
            @(posedge i_clk); #1;
            cyc++;
            if (cyc == 2) bus.i_val = 1'b0;
        end
        bus.i_val = 1'b0;
        chk({tag, " latency"}, DAT_BITS'(cyc), DAT_BITS'(NC + exp_s + 2));
        chk({tag, " dat"}, bus.o_dat, exp_dat);
        chk({tag, " ovf"}, DAT_BITS'(bus.o_ovf), DAT_BITS'(exp_ovf));
`ifdef REDUN_COLLAPSE_CNT_EN
        chk({tag, " sub_cnt"}, DAT_BITS'(bus.o_sub_cnt), DAT_BITS'(exp_s));
`endif
        if (!early_rdy) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge i_clk); #1;
                if (bus.o_val !== 1'b1 || bus.o_rdy !== 1'b0 || bus.o_dat !== exp_dat
                    || bus.o_ovf !== exp_ovf) begin
                    chk({tag, " hold_stable"}, {bus.o_val, bus.o_rdy, bus.o_ovf, bus.o_dat[DAT_BITS-4:0]},
                        {1'b1, 1'b0, exp_ovf, exp_dat[DAT_BITS-4:0]});
                end else begin
                    cmp_cnt++;
                end
            end
        end
        bus.i_rdy = 1'b1;
        @(posedge i_clk); #1;
        bus.i_rdy = 1'b0;
        chk({tag, " val_drop"}, DAT_BITS'(bus.o_val), 0);
        chk({tag, " back_idle"}, DAT_BITS'(bus.o_rdy), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", cmp_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t                 vecs [5];
        redun0_t              d;
        logic [DAT_BITS-1:0]  m_dat;
        bit                   m_ovf;
        int                   m_s;
        bit                   saw_val;

        i_rst     = 1'b1;
        bus.i_val = 1'b0;
        bus.i_rdy = 1'b0;
        bus.i_dat = '0;
        #12;
        chk("reset o_rdy", DAT_BITS'(bus.o_rdy), 1);
        chk("reset o_val", DAT_BITS'(bus.o_val), 0);
        chk("reset o_ovf", DAT_BITS'(bus.o_ovf), 0);
        chk("reset o_dat", bus.o_dat, '0);
`ifdef REDUN_COLLAPSE_CNT_EN
        chk("reset o_sub_cnt", DAT_BITS'(bus.o_sub_cnt), 0);
`endif
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // Directed table
        vecs[0] = '{dat: to_redun('0), exp_dat: '0, exp_ovf: 1'b0, exp_s: 0, hold: 0};
        d = '0;
        d.wrd[0] = 17'h10000;
        vecs[1] = '{dat: d, exp_dat: 128'h1_0000, exp_ovf: 1'b0, exp_s: 0, hold: 0};
        vecs[2] = '{dat: to_redun(P), exp_dat: '0, exp_ovf: 1'b0, exp_s: 1, hold: 0};
        vecs[3] = '{dat: to_redun(P + P + 128'd5), exp_dat: 128'd5, exp_ovf: 1'b0, exp_s: 2, hold: 10};
        vecs[4] = '{dat: to_redun(P + P + P), exp_dat: P, exp_ovf: 1'b1, exp_s: 2, hold: 3};
        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].dat, vecs[i].exp_dat, vecs[i].exp_ovf, vecs[i].exp_s,
                    vecs[i].hold, 1'b0, (i == 1), $sformatf("vec%0d", i));
        end

        // Reset during CARRY discards the transaction
        bus.i_dat = to_redun(P + 128'd1);
        bus.i_val = 1'b1;
        @(posedge i_clk); #1;
        bus.i_val = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        #1;
        chk("midrst o_rdy", DAT_BITS'(bus.o_rdy), 1);
        chk("midrst o_val", DAT_BITS'(bus.o_val), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        chk("midrst rdy_after", DAT_BITS'(bus.o_rdy), 1);
        saw_val = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge i_clk); #1;
            if (bus.o_val !== 1'b0) saw_val = 1'b1;
        end
        chk("midrst no_val", DAT_BITS'(saw_val), 0);
        run_txn(to_redun(128'd7), 128'd7, 1'b0, 0, 0, 1'b0, 1'b0, "after_rst");

        // All-ones redundant words: every carry bit must survive
        for (int i = 0; i < int'(NUM_WRDS); i++) d.wrd[i] = 17'h1FFFF;
        model(d, m_dat, m_ovf, m_s);
        run_txn(d, m_dat, m_ovf, m_s, 1, 1'b0, 1'b0, "all_ones");

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            int unsigned mode;
            mode = $urandom_range(0, 2);
            for (int i = 0; i < int'(NUM_WRDS); i++) d.wrd[i] = 17'($urandom_range(0, 17'h1FFFF));
            case (mode)
                0: d.wrd[NUM_WRDS-1] = 17'($urandom_range(0, 17'h1FFFF));
                1: d.wrd[NUM_WRDS-1] = 17'($urandom_range(0, 16'h5FFF));
                default: d.wrd[NUM_WRDS-1] = 17'($urandom_range(0, 16'h1FFF));
            endcase
            model(d, m_dat, m_ovf, m_s);
            run_txn(d, m_dat, m_ovf, m_s, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'b0, $sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mism_cnt);
        $finish;
    end

endmodule
